// File: rtl/rv32i_fetch_pkg.sv
// Shared types and constants for the RV32I instruction-fetch front end.
package rv32i_fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; push while full is accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Explicit wrap so non-power-of-2 depths work as well.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    full     = (count == CW'(DEPTH));
    empty    = (count == '0);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    pop_data = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: issues in-order imem requests, buffers PC-tagged responses,
// hands them to decode, and flushes on redirect.
module if_fetch_queue
  import rv32i_fetch_pkg::*;
#(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc_plus4
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int FW = $clog2(DEPTH + 1);
  localparam int EW = $bits(fetch_entry_t);

  logic [31:0]   fetch_pc;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] drop_cnt;

  logic          req_fire;
  logic          rsp_any;
  logic          tag_pop;
  logic          entry_push;
  logic          entry_pop;

  logic [31:0]   tag_head;
  logic [OW-1:0] tag_count;
  logic          tag_full;
  logic          tag_empty;

  fetch_entry_t  entry_in;
  fetch_entry_t  head;
  logic [EW-1:0] entry_rdata;
  logic [FW-1:0] fifo_count;
  logic          entry_full;
  logic          entry_empty;

  // Stale responses (drop_cnt > 0) never touch the tag queue, which may already
  // hold tags for requests to the new PC; a response with nothing to match is ignored.
  always_comb begin
    imem_req_valid = rst_n && !redirect_valid
                  && (outstanding < OW'(MAX_OUTSTANDING))
                  && ((32'(fifo_count) + 32'(outstanding)) < 32'(DEPTH));
    imem_req_addr  = fetch_pc;
    req_fire       = imem_req_valid && imem_req_ready;
    rsp_any        = imem_rsp_valid && ((drop_cnt != '0) || !tag_empty);
    tag_pop        = imem_rsp_valid && (drop_cnt == '0) && !tag_empty;
    entry_push     = tag_pop && !redirect_valid;
    entry_in.pc    = tag_head;
    entry_in.instr = imem_rsp_data;
    head           = fetch_entry_t'(entry_rdata);
    inst_valid     = !entry_empty;
    entry_pop      = inst_valid && inst_ready;
    inst_data      = entry_empty ? NOP_INSTR : head.instr;
    inst_pc        = head.pc;
    inst_pc_plus4  = head.pc + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      if (redirect_valid) begin
        fetch_pc <= redirect_pc & ~32'h3;
        drop_cnt <= outstanding - OW'(rsp_any);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (rsp_any && (drop_cnt != '0)) drop_cnt <= drop_cnt - OW'(1);
      end
      outstanding <= outstanding + OW'(req_fire) - OW'(rsp_any);
    end
  end

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (req_fire),
    .push_data (fetch_pc),
    .pop       (tag_pop),
    .pop_data  (tag_head),
    .count     (tag_count),
    .full      (tag_full),
    .empty     (tag_empty)
  );

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_entry_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (entry_push),
    .push_data (entry_in),
    .pop       (entry_pop),
    .pop_data  (entry_rdata),
    .count     (fifo_count),
    .full      (entry_full),
    .empty     (entry_empty)
  );

  // Every outstanding request is either awaiting a drop or owns a tag; credits prevent overflow.
  a_credit_balance: assert property (@(posedge clk) disable iff (!rst_n)
    outstanding == drop_cnt + tag_count);
  a_tag_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(tag_full && req_fire && !tag_pop));
  a_entry_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(entry_full && entry_push && !entry_pop));

endmodule
